// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared CPU definitions for the exception redirect sequencer: FSM states,
// exception vector addresses and the interrupt-pending helper.
package exc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRedirect
  } redirect_state_t;

  localparam logic [31:0] VEC_GENERAL_RAM  = 32'h8000_0180;
  localparam logic [31:0] VEC_INT_RAM      = 32'h8000_0200;
  localparam logic [31:0] VEC_GENERAL_BOOT = 32'hbfc0_0380;
  localparam logic [31:0] VEC_INT_BOOT     = 32'hbfc0_0400;

  localparam logic [4:0] EX_INT = 5'd0;

  // An interrupt may be taken only with IE set, outside exception/error level.
  function automatic logic irq_pending(input logic       ie,
                                       input logic       exl,
                                       input logic       erl,
                                       input logic [7:0] im,
                                       input logic [7:0] ip);
    return ie & ~exl & ~erl & (|(im & ip));
  endfunction

endpackage

// File: rtl/exc_redirect_ctrl_if.sv
// Bundle between write-back/CP0/fetch and the redirect sequencer.
// master: the pipeline side driving events and CP0 state; slave: the sequencer.
interface exc_redirect_ctrl_if;
  logic        wb_valid;
  logic        wb_exc_valid;
  logic [4:0]  wb_exc_code;
  logic        wb_eret;
  logic        status_ie;
  logic        status_exl;
  logic        status_erl;
  logic        status_bev;
  logic        cause_iv;
  logic [7:0]  status_im;
  logic [7:0]  cause_ip;
  logic [31:0] epc;
  logic [31:0] error_epc;
  logic        int_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  modport master (
    output wb_valid, wb_exc_valid, wb_exc_code, wb_eret,
    output status_ie, status_exl, status_erl, status_bev, cause_iv,
    output status_im, cause_ip, epc, error_epc, redirect_ready,
    input  int_req, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  wb_valid, wb_exc_valid, wb_exc_code, wb_eret,
    input  status_ie, status_exl, status_erl, status_bev, cause_iv,
    input  status_im, cause_ip, epc, error_epc, redirect_ready,
    output int_req, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_vector_sel.sv
// Combinational fetch-target selection for exceptions and ERET.
module exc_vector_sel
  import exc_redirect_ctrl_pkg::*;
(
  input  logic [4:0]  i_code,
  input  logic        i_bev,
  input  logic        i_iv,
  input  logic        i_eret,
  input  logic        i_erl,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_error_epc,
  output logic [31:0] o_target_pc
);

  // ERET returns through ErrorEPC at error level, else EPC; exceptions pick a vector.
  always_comb begin
    o_target_pc = VEC_GENERAL_RAM;
    if (i_eret) begin
      o_target_pc = i_erl ? i_error_epc : i_epc;
    end else if (i_code == EX_INT) begin
      unique case ({i_bev, i_iv})
        2'b00:   o_target_pc = VEC_GENERAL_RAM;
        2'b01:   o_target_pc = VEC_INT_RAM;
        2'b10:   o_target_pc = VEC_GENERAL_BOOT;
        default: o_target_pc = VEC_INT_BOOT;
      endcase
    end else begin
      o_target_pc = i_bev ? VEC_GENERAL_BOOT : VEC_GENERAL_RAM;
    end
  end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Turns retired exceptions / ERET into a timed pipeline flush followed by a
// fetch redirect handshake, and raises int_req for pending interrupts.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  // Flush length in cycles after an event; legal range 1..15.
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  exc_redirect_ctrl_if.slave io_bus
);

  localparam logic [3:0] CntInit = 4'(FLUSH_CYCLES - 1);

  redirect_state_t r_state, w_state_d;
  logic [3:0]      r_cnt, w_cnt_d;
  logic [31:0]     r_target, w_target_d;
  logic            r_int_req, w_int_req_d;
  logic [31:0]     w_vec_pc;
  logic            w_event;
  logic            w_is_eret;
  logic            w_pending;

  assign w_event   = io_bus.wb_valid & (io_bus.wb_exc_valid | io_bus.wb_eret);
  // Exception takes priority when both flags accompany the same instruction.
  assign w_is_eret = io_bus.wb_eret & ~io_bus.wb_exc_valid;
  assign w_pending = irq_pending(io_bus.status_ie, io_bus.status_exl, io_bus.status_erl,
                                 io_bus.status_im, io_bus.cause_ip);

  exc_vector_sel u_vec_sel (
    .i_code      (io_bus.wb_exc_code),
    .i_bev       (io_bus.status_bev),
    .i_iv        (io_bus.cause_iv),
    .i_eret      (w_is_eret),
    .i_erl       (io_bus.status_erl),
    .i_epc       (io_bus.epc),
    .i_error_epc (io_bus.error_epc),
    .o_target_pc (w_vec_pc)
  );

  // Next-state logic: IDLE -> FLUSH (cnt cycles) -> REDIRECT until accepted.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_target_d = r_target;
    unique case (r_state)
      StIdle: begin
        if (w_event) begin
          w_state_d  = StFlush;
          w_cnt_d    = CntInit;
          w_target_d = w_vec_pc;
        end
      end
      StFlush: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StRedirect;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StRedirect: begin
        if (io_bus.redirect_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Only request while idle and not already taking an event this cycle.
    w_int_req_d = w_pending & (r_state == StIdle) & ~w_event;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_target  <= 32'd0;
      r_int_req <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_target  <= w_target_d;
      r_int_req <= w_int_req_d;
    end
  end

  // Outputs decode registered state only.
  assign io_bus.flush          = (r_state == StFlush);
  assign io_bus.redirect_valid = (r_state == StRedirect);
  assign io_bus.redirect_pc    = r_target;
  assign io_bus.int_req        = r_int_req;
  assign io_bus.busy           = (r_state != StIdle);

endmodule
